// File: rtl/bcd_counter_n_if.sv
// Control and status bundle for bcd_counter_n; the master drives the control
// strobes and load data, the slave (the counter) returns the count and flags.
interface bcd_counter_n_if #(
  parameter int DIGITS = 3
);
  logic                  clear;
  logic                  enable;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   bcd;
  logic                  tc;
  logic                  ovf;
  logic                  at_max;
  logic                  at_zero;

  modport master (
    output clear, enable, up, load, load_value,
    input  bcd, tc, ovf, at_max, at_zero
  );

  modport slave (
    input  clear, enable, up, load, load_value,
    output bcd, tc, ovf, at_max, at_zero
  );
endinterface

// File: rtl/bcd_counter_n.sv
// N-digit up/down BCD counter with parallel load, terminal-count and sticky overflow.
// Define BCD_COUNTER_N_SATURATE_EN to saturate at the terminal value instead of wrapping.
module bcd_counter_n #(
  parameter int DIGITS   = 3,
  parameter bit TC_LEVEL = 1'b0
) (
  input  logic           clock,
  input  logic           resetn,
  bcd_counter_n_if.slave bus
);

  typedef logic [3:0] digit_t;
  localparam digit_t NINE = 4'd9;

  logic [DIGITS-1:0][3:0] count_q, count_d;
  logic [DIGITS-1:0][3:0] inc_val, dec_val, load_sat;
  logic                   tc_q, tc_d;
  logic                   ovf_q, ovf_d;
  logic                   all_nine, all_zero;
  logic                   carry, borrow;
  logic                   terminal;
  digit_t                 ld_digit;

  // Digit-wise ripple: a digit moves only while every lower digit rolled over.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    all_nine = 1'b1;
    all_zero = 1'b1;
    carry    = 1'b1;
    borrow   = 1'b1;
    inc_val  = count_q;
    dec_val  = count_q;
    load_sat = '0;
    ld_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      all_nine = all_nine & (count_q[k] == NINE);
      all_zero = all_zero & (count_q[k] == 4'd0);
      if (carry) begin
        if (count_q[k] == NINE) begin
          inc_val[k] = 4'd0;
        end else begin
          inc_val[k] = count_q[k] + 4'd1;
          carry      = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[k] == 4'd0) begin
          dec_val[k] = NINE;
        end else begin
          dec_val[k] = count_q[k] - 4'd1;
          borrow     = 1'b0;
        end
      end
      ld_digit    = bus.load_value[4*k +: 4];
      load_sat[k] = (ld_digit > NINE) ? NINE : ld_digit;
    end
  end

  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    tc_d     = 1'b0;
    terminal = 1'b0;
    if (bus.clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      count_d = load_sat;
    end else if (bus.enable) begin
      terminal = bus.up ? all_nine : all_zero;
      if (terminal) begin
        ovf_d = 1'b1;
        tc_d  = ~TC_LEVEL;
      end
`ifdef BCD_COUNTER_N_SATURATE_EN
      if (!terminal) begin
        count_d = bus.up ? inc_val : dec_val;
      end
`else
      // Wrap falls out of the ripple: all-9 + 1 is all-0 and all-0 - 1 is all-9.
      count_d = bus.up ? inc_val : dec_val;
`endif
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.bcd     = count_q;
  assign bus.ovf     = ovf_q;
  assign bus.at_max  = all_nine;
  assign bus.at_zero = all_zero;
  assign bus.tc      = TC_LEVEL ? (bus.up ? all_nine : all_zero) : tc_q;

endmodule
